// File: rtl/pipe_adder.sv
// Pipelined two's-complement adder/subtractor. Each stage adds one CHUNK-wide slice and
// passes the carry on; unused operand slices ride along in skew registers.
module pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  // One enable for the whole pipe: it moves only when the output slot is free or being taken.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int TW = WIDTH - k * CHUNK;

    logic [TW-1:0]            a_top;
    logic [TW-1:0]            b_top;
    logic                     c_in;
    logic                     v_in;
    logic [CHUNK:0]           sum;
    logic [(k+1)*CHUNK-1:0]   r_d;
    logic [(k+1)*CHUNK-1:0]   r_q;
    logic                     c_q;
    logic                     v_q;

    assign sum = {1'b0, a_top[CHUNK-1:0]} + {1'b0, b_top[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_in};

    if (k == 0) begin : g_head
      assign a_top = a;
      assign b_top = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign r_d   = sum[CHUNK-1:0];
    end else begin : g_body
      assign a_top = g_stage[k-1].g_skew.a_q;
      assign b_top = g_stage[k-1].g_skew.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign r_d   = {sum[CHUNK-1:0], g_stage[k-1].r_q};
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= sum[CHUNK];
        r_q <= r_d;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [TW-CHUNK-1:0] a_q;
      logic [TW-CHUNK-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_top[TW-1:CHUNK];
          b_q <= b_top[TW-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      // Carry into the MSB is a^b^sum at that bit; overflow is that XOR the carry out.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= a_top[CHUNK-1] ^ b_top[CHUNK-1] ^ sum[CHUNK-1] ^ sum[CHUNK];
        end
      end

      assign s         = r_q;
      assign cout      = c_q;
      assign ovf       = ovf_q;
      assign out_valid = v_q;
    end
  end

endmodule
